// File: rtl/multi_btn_debounce_pkg.sv
// rtl/multi_btn_debounce_pkg.sv - shared types for the multi-channel button debouncer
// Package btn_debounce_pkg: btn_state_e, the per-channel debounce FSM state (2-bit).
package btn_debounce_pkg;

    typedef enum logic [1:0] {
        RELEASED        = 2'd0,
        CONFIRM_PRESS   = 2'd1,
        PRESSED         = 2'd2,
        CONFIRM_RELEASE = 2'd3
    } btn_state_e;

endpackage

// File: rtl/multi_btn_debounce_ch.sv
// rtl/multi_btn_debounce_ch.sv - single-channel synchroniser, debounce FSM and pulse generator
// Module btn_debounce_ch
//   sysclk           in   system clock, rising edge
//   reset            in   asynchronous active-high reset
//   btn              in   raw asynchronous button pin, 1 = pressed
//   btn_level        out  debounced level
//   press_pulse      out  one-cycle pulse on committed press
//   release_pulse    out  one-cycle pulse on committed release
//   long_press_pulse out  one-cycle pulse once per press held LONG_PRESS_CYCLES
// Optional macro MULTI_BTN_LONG_PRESS_EN: when undefined the hold counter is
// absent and long_press_pulse is tied low.
module btn_debounce_ch
    import btn_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 255,
    parameter int LONG_PRESS_CYCLES = 50_000_000
) (
    input  logic sysclk,
    input  logic reset,
    input  logic btn,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press_pulse
);

    localparam int DBC_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DBC_W-1:0] DBC_LAST = DBC_W'(DEBOUNCE_CYCLES - 1);

    (* ASYNC_REG = "TRUE" *) logic sync_1;
    (* ASYNC_REG = "TRUE" *) logic sync_2;

    btn_state_e       state, state_nxt;
    logic [DBC_W-1:0] dbc_cnt, dbc_nxt;
    logic             level_nxt, press_nxt, release_nxt;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= btn;
            sync_2 <= sync_1;
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state         <= RELEASED;
            dbc_cnt       <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_nxt;
            dbc_cnt       <= dbc_nxt;
            btn_level     <= level_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
        end
    end

    // The FSM only ever looks at the synchronised sample sync_2.
    always_comb begin
        state_nxt   = state;
        dbc_nxt     = dbc_cnt;
        level_nxt   = btn_level;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        case (state)
            RELEASED: begin
                if (sync_2) begin
                    state_nxt = CONFIRM_PRESS;
                    dbc_nxt   = '0;
                end
            end
            CONFIRM_PRESS: begin
                if (!sync_2) begin
                    state_nxt = RELEASED;
                end else if (dbc_cnt == DBC_LAST) begin
                    state_nxt = PRESSED;
                    press_nxt = 1'b1;
                    level_nxt = 1'b1;
                end else begin
                    dbc_nxt = dbc_cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!sync_2) begin
                    state_nxt = CONFIRM_RELEASE;
                    dbc_nxt   = '0;
                end
            end
            CONFIRM_RELEASE: begin
                if (sync_2) begin
                    state_nxt = PRESSED;
                end else if (dbc_cnt == DBC_LAST) begin
                    state_nxt   = RELEASED;
                    release_nxt = 1'b1;
                    level_nxt   = 1'b0;
                end else begin
                    dbc_nxt = dbc_cnt + 1'b1;
                end
            end
            default: state_nxt = RELEASED;
        endcase
    end

`ifdef MULTI_BTN_LONG_PRESS_EN
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);

    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic              long_nxt;
    logic              hold_active;

    // Hold time keeps running through CONFIRM_RELEASE so a release bounce
    // does not restart long-press timing; saturation at HOLD_MAX makes the
    // pulse fire only once per press.
    assign hold_active = (state == PRESSED) || (state == CONFIRM_RELEASE);

    always_comb begin
        hold_nxt = hold_cnt;
        long_nxt = 1'b0;
        if (press_nxt) begin
            hold_nxt = '0;
        end else if (hold_active && (hold_cnt != HOLD_MAX)) begin
            hold_nxt = hold_cnt + 1'b1;
            long_nxt = (hold_cnt == HOLD_LAST);
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            hold_cnt         <= '0;
            long_press_pulse <= 1'b0;
        end else begin
            hold_cnt         <= hold_nxt;
            long_press_pulse <= long_nxt;
        end
    end
`else
    assign long_press_pulse = 1'b0;
`endif

endmodule

// File: rtl/multi_btn_debounce.sv
// rtl/multi_btn_debounce.sv - NUM_BTNS independent button debounce channels
// Module multi_btn_debounce
//   sysclk           in   system clock, rising edge
//   reset            in   asynchronous active-high reset
//   btn              in   [NUM_BTNS] raw button pins, 1 = pressed
//   btn_level        out  [NUM_BTNS] debounced levels
//   press_pulse      out  [NUM_BTNS] one-cycle committed-press pulses
//   release_pulse    out  [NUM_BTNS] one-cycle committed-release pulses
//   long_press_pulse out  [NUM_BTNS] one-cycle long-press pulses
// Optional macro MULTI_BTN_LONG_PRESS_EN enables long-press detection.
module multi_btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int NUM_BTNS          = 4,
    parameter int DEBOUNCE_CYCLES   = 255,
    parameter int LONG_PRESS_CYCLES = 50_000_000
) (
    input  logic                sysclk,
    input  logic                reset,
    input  logic [NUM_BTNS-1:0] btn,
    output logic [NUM_BTNS-1:0] btn_level,
    output logic [NUM_BTNS-1:0] press_pulse,
    output logic [NUM_BTNS-1:0] release_pulse,
    output logic [NUM_BTNS-1:0] long_press_pulse
);

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
        ) u_ch (
            .sysclk          (sysclk),
            .reset           (reset),
            .btn             (btn[i]),
            .btn_level       (btn_level[i]),
            .press_pulse     (press_pulse[i]),
            .release_pulse   (release_pulse[i]),
            .long_press_pulse(long_press_pulse[i])
        );
    end

endmodule

// File: tb/tb_multi_btn_debounce.sv
// tb/tb_multi_btn_debounce.sv - scoreboard bench for multi_btn_debounce
module tb_multi_btn_debounce;

    localparam int N = 2;
    localparam int D = 4;
    localparam int L = 10;
`ifdef MULTI_BTN_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic         sysclk;
    logic         reset;
    logic [N-1:0] btn;
    logic [N-1:0] btn_level;
    logic [N-1:0] press_pulse;
    logic [N-1:0] release_pulse;
    logic [N-1:0] long_press_pulse;

    multi_btn_debounce #(
        .NUM_BTNS         (N),
        .DEBOUNCE_CYCLES  (D),
        .LONG_PRESS_CYCLES(L)
    ) dut (
        .sysclk          (sysclk),
        .reset           (reset),
        .btn             (btn),
        .btn_level       (btn_level),
        .press_pulse     (press_pulse),
        .release_pulse   (release_pulse),
        .long_press_pulse(long_press_pulse)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    typedef struct packed {
        logic [N-1:0] level;
        logic [N-1:0] press;
        logic [N-1:0] rel;
        logic [N-1:0] lng;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   press_seen[N];
    int   long_seen[N];

    // Reference model: the filter sees the pin value from two edges ago; a
    // level change commits once that value has disagreed with the committed
    // level on D+1 consecutive edges. Long press fires on the L-th edge
    // after the press commit while the level is still high.
    bit hist1[N];
    bit hist2[N];
    bit lvl[N];
    int run[N];
    int held[N];

    always @(posedge sysclk) begin
        exp_t e;
        bit   s;
        e = '0;
        for (int c = 0; c < N; c++) begin
            if (reset) begin
                hist1[c] = 1'b0;
                hist2[c] = 1'b0;
                lvl[c]   = 1'b0;
                run[c]   = 0;
                held[c]  = 0;
            end else begin
                s        = hist2[c];
                hist2[c] = hist1[c];
                hist1[c] = btn[c];
                if (lvl[c]) begin
                    held[c]++;
                    if (LONG_EN && held[c] == L) e.lng[c] = 1'b1;
                end
                if (s != lvl[c]) run[c]++;
                else run[c] = 0;
                if (run[c] == D + 1) begin
                    lvl[c] = ~lvl[c];
                    run[c] = 0;
                    if (lvl[c]) begin
                        e.press[c] = 1'b1;
                        held[c]    = 0;
                    end else begin
                        e.rel[c] = 1'b1;
                    end
                end
            end
            e.level[c] = lvl[c];
        end
        exp_q.push_back(e);
    end

    // Monitor: pops one expectation per cycle and compares the DUT outputs.
    always begin
        exp_t e;
        exp_t a;
        @(posedge sysclk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {btn_level, press_pulse, release_pulse, long_press_pulse};
            for (int c = 0; c < N; c++) begin
                if (press_pulse[c]) press_seen[c]++;
                if (long_press_pulse[c]) long_seen[c]++;
            end
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL scoreboard t=%0t actual lvl=%b prs=%b rel=%b lng=%b required lvl=%b prs=%b rel=%b lng=%b",
                         $time, a.level, a.press, a.rel, a.lng, e.level, e.press, e.rel, e.lng);
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    initial begin
        int p0, l0, p1;
        for (int c = 0; c < N; c++) begin
            press_seen[c] = 0;
            long_seen[c]  = 0;
        end
        reset = 1'b1;
        btn   = '0;
        cyc(3);
        chk("reset_outputs", int'({btn_level, press_pulse, release_pulse, long_press_pulse}), 0);
        reset = 1'b0;
        cyc(2);

        // Clean press then release on channel 0
        p0 = press_seen[0];
        l0 = long_seen[0];
        btn[0] = 1'b1;
        cyc(30);
        chk("clean_press_count", press_seen[0] - p0, 1);
        chk("long_press_once", long_seen[0] - l0, LONG_EN ? 1 : 0);
        chk("level_held", int'(btn_level[0]), 1);
        btn[0] = 1'b0;
        cyc(15);
        chk("level_released", int'(btn_level[0]), 0);
        chk("no_extra_long", long_seen[0] - l0, LONG_EN ? 1 : 0);

        // Bounce on channel 1: 3 high / 2 low, five times
        p1 = press_seen[1];
        for (int k = 0; k < 5; k++) begin
            btn[1] = 1'b1;
            cyc(3);
            btn[1] = 1'b0;
            cyc(2);
        end
        cyc(10);
        chk("bounce_no_press", press_seen[1] - p1, 0);
        chk("bounce_level", int'(btn_level[1]), 0);

        // Simultaneous press, release channel 1 only
        btn = 2'b11;
        cyc(30);
        chk("simul_level", int'(btn_level), 3);
        btn[1] = 1'b0;
        cyc(15);
        chk("simul_rel_level", int'(btn_level), 1);
        btn = '0;
        cyc(15);

        // Reset two cycles into the confirm window
        p0 = press_seen[0];
        btn[0] = 1'b1;
        cyc(4);
        reset = 1'b1;
        cyc(3);
        chk("reset_mid_outputs", int'({btn_level, press_pulse, release_pulse, long_press_pulse}), 0);
        reset = 1'b0;
        cyc(20);
        chk("reset_mid_press_count", press_seen[0] - p0, 1);
        btn = '0;
        cyc(15);

        // Randomised bouncy traffic with occasional resets
        for (int seg = 0; seg < 400; seg++) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(0, 1) == 1) btn[c] = ~btn[c];
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b1;
                cyc($urandom_range(1, 3));
                reset = 1'b0;
            end
            cyc($urandom_range(1, 14));
        end
        btn = '0;
        cyc(20);
        chk("final_level", int'(btn_level), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
